// File: rtl/regs_bank.sv
// Banked register file: one write port, two registered read ports with write-first bypass,
// and an optional zero-fill sweep after reset that holds busy high until every word is cleared.
module regs_bank #(
  parameter int WIDTH   = 16,
  parameter int REGS    = 8,
  parameter int BANKS   = 2,
  parameter bit CLR_RST = 1'b1,
  localparam int BW     = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int AW     = $clog2(REGS)
) (
  input  logic             clk_sys,
  input  logic             clm,
  input  logic             wr,
  input  logic [BW-1:0]    wbank,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] w,
  input  logic             rda,
  input  logic [BW-1:0]    rbanka,
  input  logic [AW-1:0]    raa,
  output logic [WIDTH-1:0] la,
  output logic             la_v,
  input  logic             rdb,
  input  logic [BW-1:0]    rbankb,
  input  logic [AW-1:0]    rab,
  output logic [WIDTH-1:0] lb,
  output logic             lb_v,
  output logic             busy
);

  localparam int DEPTH = BANKS * REGS;
  localparam int IW    = $clog2(DEPTH);
  localparam int CW    = IW + 1;

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  // With a single bank the select bit falls off the top of the slice.
  function automatic logic [IW-1:0] flat_idx(input logic [BW-1:0] bank,
                                             input logic [AW-1:0] addr);
    logic [BW+AW-1:0] cat;
    cat = {bank, addr};
    return cat[IW-1:0];
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] la_q, la_d, lb_q, lb_d;
  logic             la_v_q, la_v_d, lb_v_q, lb_v_d;

  logic             mem_we;
  logic [IW-1:0]    mem_widx;
  logic [WIDTH-1:0] mem_wdata;
  logic [IW-1:0]    widx, ridx_a, ridx_b;

  assign widx   = flat_idx(wbank, wa);
  assign ridx_a = flat_idx(rbanka, raa);
  assign ridx_b = flat_idx(rbankb, rab);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    la_d      = la_q;
    lb_d      = lb_q;
    la_v_d    = 1'b0;
    lb_v_d    = 1'b0;
    mem_we    = 1'b0;
    mem_widx  = widx;
    mem_wdata = w;

    if (state_q == ST_CLEAR) begin
      mem_we    = !clm;
      mem_widx  = cnt_q[IW-1:0];
      mem_wdata = '0;
      cnt_d     = cnt_q + 1'b1;
      if (cnt_q == CW'(DEPTH - 1)) begin
        state_d = ST_RUN;
        busy_d  = 1'b0;
      end
    end else begin
      mem_we = wr && !clm;
      la_v_d = rda;
      lb_v_d = rdb;
      // Write-first: a read hitting the word being written sees the incoming data.
      if (rda) la_d = (wr && (widx == ridx_a)) ? w : mem_q[ridx_a];
      if (rdb) lb_d = (wr && (widx == ridx_b)) ? w : mem_q[ridx_b];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (clm) begin
      state_q <= CLR_RST ? ST_CLEAR : ST_RUN;
      cnt_q   <= '0;
      busy_q  <= CLR_RST;
      la_q    <= '0;
      lb_q    <= '0;
      la_v_q  <= 1'b0;
      lb_v_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      la_q    <= la_d;
      lb_q    <= lb_d;
      la_v_q  <= la_v_d;
      lb_v_q  <= lb_v_d;
    end
  end

  // NOTE: storage has no reset; the clear sweep (or nothing, when CLR_RST=0) defines its contents.
  always_ff @(posedge clk_sys) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  assign la   = la_q;
  assign la_v = la_v_q;
  assign lb   = lb_q;
  assign lb_v = lb_v_q;
  assign busy = busy_q;

endmodule
